// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-sequence detector.
package seq_det_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Widest pattern the mask helper can describe; callers truncate to their own width.
  localparam int MASK_MAX_W = 64;

  function automatic logic [MASK_MAX_W-1:0] low_mask(input int len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: Moore match pulse plus saturating
// match counter, overlapping or non-overlapping detection.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] PAT_LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] nhist;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] nfill;
  logic [LEN_W-1:0] len_eff;
  logic             hit;
  logic             accept;

  always_comb begin
    accept   = in_valid && !clear;
    nhist    = {hist_q[PAT_W-2:0], data};
    nfill    = (fill_q >= PAT_LEN_MAX) ? PAT_LEN_MAX : fill_q + 1'b1;
    len_eff  = (pat_len > PAT_LEN_MAX) ? PAT_LEN_MAX : pat_len;
    len_mask = PAT_W'(low_mask(int'(len_eff)));
    // fill guards against matching on stale bits left over from before a clear/restart
    hit      = (len_eff != '0) && (nfill >= len_eff) &&
               ((nhist & len_mask) == (pattern & len_mask));

    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d  = nhist;
      match_d = hit;
      fill_d  = (hit && (overlap == MODE_NONOVL)) ? '0 : nfill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && hit),
    .clr   (clear),
    .count (match_count)
  );

  assign match = match_q;

endmodule
